// File: rtl/tone_pkg.sv
// Shared tone codes, step encoding and state type for the tone contour generator
// and the matching detector.
package tone_pkg;

    localparam logic [2:0] TONE_NEUTRAL    = 3'b000;
    localparam logic [2:0] TONE_RISING     = 3'b001;
    localparam logic [2:0] TONE_UNDULATING = 3'b010;
    localparam logic [2:0] TONE_FALLING    = 3'b100;

    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_UP   = 2'b01,
        STEP_DOWN = 2'b11
    } step_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_DONE
    } state_e;

    // Index b holds the step applied at the boundary from segment b to b+1.
    typedef logic [2:0][1:0] step_seq_t;

    function automatic logic tone_valid(input logic [2:0] code);
        case (code)
            TONE_NEUTRAL, TONE_RISING, TONE_UNDULATING, TONE_FALLING: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic step_seq_t tone_steps(input logic [2:0] code);
        case (code)
            TONE_RISING:     return {STEP_UP,   STEP_UP,   STEP_UP};
            TONE_UNDULATING: return {STEP_DOWN, STEP_UP,   STEP_UP};
            TONE_FALLING:    return {STEP_DOWN, STEP_DOWN, STEP_DOWN};
            default:         return {STEP_NONE, STEP_NONE, STEP_NONE};
        endcase
    endfunction

endpackage

// File: rtl/tone_contour_gen_if.sv
// Request/sample bundle between a tone contour requester and the generator.
interface tone_contour_gen_if #(
    parameter int PHASE_W  = 32,
    parameter int SAMPLE_W = 8
) ();
    logic                valid_in;
    logic                ready_out;
    logic [2:0]          tone_ident_in;
    logic [PHASE_W-1:0]  base_inc_in;
    logic [31:0]         segment_length_in;
    logic [SAMPLE_W-1:0] sample_out;
    logic                sample_valid_out;
    logic [1:0]          segment_out;
    logic                done_out;
    logic                error_out;

    modport master (
        output valid_in, tone_ident_in, base_inc_in, segment_length_in,
        input  ready_out, sample_out, sample_valid_out, segment_out, done_out, error_out
    );

    modport slave (
        input  valid_in, tone_ident_in, base_inc_in, segment_length_in,
        output ready_out, sample_out, sample_valid_out, segment_out, done_out, error_out
    );
endinterface

// File: rtl/tone_nco.sv
// Phase accumulator with sample formatting and sample strobe divider.
// Define TONE_GEN_SQUARE_EN for a square-wave output instead of the sawtooth.
module tone_nco #(
    parameter int PHASE_W    = 32,
    parameter int SAMPLE_W   = 8,
    parameter int SAMPLE_DIV = 1
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                load,
    input  logic                run,
    input  logic [PHASE_W-1:0]  inc,
    output logic [SAMPLE_W-1:0] sample,
    output logic                strobe
);
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [PHASE_W-1:0] phase;
    logic [DIV_W-1:0]   div_cnt;

    // NOTE: all state updates use <= so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            phase   <= '0;
            div_cnt <= '0;
        end else if (load) begin
            phase   <= '0;
            div_cnt <= '0;
        end else if (run) begin
            phase   <= phase + inc;
            div_cnt <= (div_cnt == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_cnt + 1'b1;
        end
    end

    assign strobe = run && (div_cnt == '0);

    // The sample is a direct slice of the phase register, i.e. the pre-add phase.
`ifdef TONE_GEN_SQUARE_EN
    assign sample = {SAMPLE_W{phase[PHASE_W-1]}};
`else
    assign sample = phase[PHASE_W-1 -: SAMPLE_W];
`endif

endmodule

// File: rtl/tone_contour_gen.sv
// Tone contour generator: FSM, segment counter and per-segment increment update
// around a phase-accumulator NCO.
module tone_contour_gen
    import tone_pkg::*;
#(
    parameter int PHASE_W    = 32,
    parameter int SAMPLE_W   = 8,
    parameter int STEP_SHIFT = 2,
    parameter int SAMPLE_DIV = 1
) (
    input  logic               clk_in,
    input  logic               rst_in,
    tone_contour_gen_if.slave  bus
);
    state_e             state, state_nxt;
    logic               accept, load, run, seg_last;
    logic [2:0]         tone_q;
    logic [PHASE_W-1:0] base_q, inc;
    logic [31:0]        len_q, seg_cnt;
    logic [1:0]         seg;
    logic               error_q;
    step_seq_t          steps;
    logic [1:0]         step_cur;

    // Up-steps saturate on carry; down-steps cannot underflow since the delta is a fraction of inc.
    function automatic logic [PHASE_W-1:0] next_inc(input logic [PHASE_W-1:0] cur,
                                                    input logic [1:0] dir);
        logic [PHASE_W:0]   sum;
        logic [PHASE_W-1:0] delta;
        delta = cur >> STEP_SHIFT;
        sum   = {1'b0, cur} + {1'b0, delta};
        case (dir)
            STEP_UP:   return sum[PHASE_W] ? '1 : sum[PHASE_W-1:0];
            STEP_DOWN: return cur - delta;
            default:   return cur;
        endcase
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load      = 1'b0;
        run       = 1'b0;
        seg_last  = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = bus.valid_in;
                if (accept && tone_valid(bus.tone_ident_in)) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                load      = 1'b1;
                state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                run      = 1'b1;
                seg_last = (seg_cnt == len_q - 32'd1);
                if (seg_last && seg == 2'd3) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        steps = tone_steps(tone_q);
        case (seg)
            2'd0:    step_cur = steps[0];
            2'd1:    step_cur = steps[1];
            2'd2:    step_cur = steps[2];
            default: step_cur = STEP_NONE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tone_q  <= TONE_NEUTRAL;
            base_q  <= '0;
            len_q   <= 32'd1;
            inc     <= '0;
            seg     <= 2'd0;
            seg_cnt <= 32'd0;
            error_q <= 1'b0;
        end else begin
            error_q <= accept && !tone_valid(bus.tone_ident_in);
            if (accept) begin
                tone_q <= bus.tone_ident_in;
                base_q <= bus.base_inc_in;
                len_q  <= (bus.segment_length_in == 32'd0) ? 32'd1 : bus.segment_length_in;
            end
            if (load) begin
                inc     <= base_q;
                seg     <= 2'd0;
                seg_cnt <= 32'd0;
            end else if (run) begin
                if (seg_last) begin
                    seg_cnt <= 32'd0;
                    if (seg != 2'd3) begin
                        seg <= seg + 2'd1;
                        inc <= next_inc(inc, step_cur);
                    end
                end else begin
                    seg_cnt <= seg_cnt + 32'd1;
                end
            end
        end
    end

    tone_nco #(
        .PHASE_W    (PHASE_W),
        .SAMPLE_W   (SAMPLE_W),
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_nco (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .load   (load),
        .run    (run),
        .inc    (inc),
        .sample (bus.sample_out),
        .strobe (bus.sample_valid_out)
    );

    assign bus.ready_out   = (state == ST_IDLE);
    assign bus.done_out    = (state == ST_DONE);
    assign bus.error_out   = error_q;
    assign bus.segment_out = seg;

endmodule

// File: tb/tb_tone_contour_gen.sv
// Directed bench for tone_contour_gen: a per-cycle expectation model of the contour
// rules, one compare process, and literal checks that pin the model.
module tb_tone_contour_gen;

    typedef struct packed {
        logic       ready;
        logic       sv;
        logic       done;
        logic       err;
        logic [7:0] sample;
        logic [1:0] seg;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   last_done_cyc = 0;

    exp_t        exp_q[$];
    exp_t        cmp_e;
    logic [31:0] m_phase;
    logic [1:0]  m_seg;
    longint      m_incs[4];

    tone_contour_gen_if #(.PHASE_W(32), .SAMPLE_W(8)) bus_if ();

    tone_contour_gen dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One comparison set per cycle for which the stimulus queued an expectation.
    always @(negedge clk) begin
        if (bus_if.done_out === 1'b1) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
        if (bus_if.error_out === 1'b1) err_cnt <= err_cnt + 1;
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            check("ready_out",        longint'(bus_if.ready_out),        longint'(cmp_e.ready));
            check("sample_valid_out", longint'(bus_if.sample_valid_out), longint'(cmp_e.sv));
            check("sample_out",       longint'(bus_if.sample_out),       longint'(cmp_e.sample));
            check("segment_out",      longint'(bus_if.segment_out),      longint'(cmp_e.seg));
            check("done_out",         longint'(bus_if.done_out),         longint'(cmp_e.done));
            check("error_out",        longint'(bus_if.error_out),        longint'(cmp_e.err));
        end
    end

    function automatic exp_t idle_exp();
        exp_t e;
        e.ready  = 1'b1;
        e.sv     = 1'b0;
        e.done   = 1'b0;
        e.err    = 1'b0;
        e.sample = m_phase[31:24];
        e.seg    = m_seg;
        return e;
    endfunction

    // Increment after boundary b, straight from the contour table and 25 % step rule.
    function automatic longint next_model(input longint cur, input logic [2:0] tone, input int b);
        int     dir;
        longint r;
        case (tone)
            3'b001:  dir = 1;
            3'b010:  dir = (b == 2) ? -1 : 1;
            3'b100:  dir = -1;
            default: dir = 0;
        endcase
        r = cur;
        if (dir > 0) begin
            r = cur + cur / 4;
            if (r > 64'hFFFF_FFFF) r = 64'hFFFF_FFFF;
        end else if (dir < 0) begin
            r = cur - cur / 4;
        end
        return r;
    endfunction

    task automatic tick(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic play(input logic [2:0] tone, input logic [31:0] base, input logic [31:0] len,
                        input bit hold, input int abort_at, output int acc_cyc);
        exp_t e;
        int   l;
        int   idx;
        bus_if.valid_in          = 1'b1;
        bus_if.tone_ident_in     = tone;
        bus_if.base_inc_in       = base;
        bus_if.segment_length_in = len;
        acc_cyc = cyc;
        tick(idle_exp());
        if (!hold) bus_if.valid_in = 1'b0;

        if (!(tone inside {3'b000, 3'b001, 3'b010, 3'b100})) begin
            e = idle_exp();
            e.err = 1'b1;
            tick(e);
            tick(idle_exp());
            return;
        end

        l = (len == 32'd0) ? 1 : int'(len);
        m_incs[0] = longint'(base);
        for (int b = 0; b < 3; b++) m_incs[b+1] = next_model(m_incs[b], tone, b);

        e = idle_exp();
        e.ready = 1'b0;
        tick(e);
        m_phase = 32'd0;
        m_seg   = 2'd0;

        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < l; c++) begin
                idx      = s * l + c;
                e.ready  = 1'b0;
                e.sv     = 1'b1;
                e.done   = 1'b0;
                e.err    = 1'b0;
                e.sample = m_phase[31:24];
                e.seg    = 2'(s);
                exp_q.push_back(e);
                if (idx == abort_at) begin
                    rst = 1'b1;
                    bus_if.valid_in = 1'b1;
                end
                @(posedge clk);
                #1;
                if (idx == abort_at) begin
                    m_phase = 32'd0;
                    m_seg   = 2'd0;
                    tick(idle_exp());
                    rst = 1'b0;
                    bus_if.valid_in = 1'b0;
                    tick(idle_exp());
                    return;
                end
                m_phase = m_phase + m_incs[s][31:0];
                m_seg   = 2'(s);
            end
        end

        bus_if.valid_in = 1'b0;
        e = idle_exp();
        e.ready = 1'b0;
        e.done  = 1'b1;
        tick(e);
        tick(idle_exp());
    endtask

    initial begin
        int acc;
        rst                      = 1'b1;
        bus_if.valid_in          = 1'b0;
        bus_if.tone_ident_in     = 3'b000;
        bus_if.base_inc_in       = 32'd0;
        bus_if.segment_length_in = 32'd0;
        m_phase = 32'd0;
        m_seg   = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick(idle_exp());
        tick(idle_exp());

        play(3'b000, 32'h0100_0000, 32'd8, 1'b0, -1, acc);
        check("neutral_final_phase", longint'(m_phase), 64'h2000_0000);
        check("neutral_done_latency", longint'(last_done_cyc - acc), 34);
        check("neutral_idle_sample", longint'(bus_if.sample_out), 64'h20);
        check("neutral_done_count", longint'(done_cnt), 1);

        play(3'b001, 32'h0100_0000, 32'd8, 1'b1, -1, acc);
        check("rising_inc1", m_incs[1], 64'h0140_0000);
        check("rising_inc2", m_incs[2], 64'h0190_0000);
        check("rising_inc3", m_incs[3], 64'h01F4_0000);
        check("rising_done_count", longint'(done_cnt), 2);

        play(3'b100, 32'h0100_0000, 32'd5, 1'b0, -1, acc);
        check("falling_inc1", m_incs[1], 64'h00C0_0000);
        check("falling_inc2", m_incs[2], 64'h0090_0000);
        check("falling_inc3", m_incs[3], 64'h006C_0000);

        play(3'b010, 32'h0100_0000, 32'd3, 1'b0, -1, acc);
        check("undulating_inc3", m_incs[3], 64'h012C_0000);

        play(3'b011, 32'h0100_0000, 32'd8, 1'b0, -1, acc);
        check("invalid_error_pulses", longint'(err_cnt), 1);

        play(3'b001, 32'hF000_0000, 32'd2, 1'b0, -1, acc);
        check("saturate_inc1", m_incs[1], 64'hFFFF_FFFF);
        check("saturate_done_latency", longint'(last_done_cyc - acc), 10);

        // Abort in the fourth cycle of segment 2 with valid_in held throughout.
        play(3'b001, 32'h0100_0000, 32'd8, 1'b1, 19, acc);
        check("abort_no_done", longint'(done_cnt), 5);
        check("abort_no_error", longint'(err_cnt), 1);

        play(3'b000, 32'd0, 32'd0, 1'b0, -1, acc);
        check("zero_len_done_latency", longint'(last_done_cyc - acc), 6);

        play(3'b010, 32'h0800_0000, 32'd4, 1'b0, -1, acc);
        check("after_abort_done_count", longint'(done_cnt), 7);
        check("queue_drained", longint'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tone_contour_gen.md
# tone_contour_gen

Tone-contour synthesizer: the transmit-side counterpart of the tone detection FSM. It accepts one 3-bit tone identifier plus a base phase increment and plays a four-segment pitch contour (neutral, rising, undulating, falling) through a phase accumulator. Sample output feeds the audio output path. The step size is chosen so each segment-to-segment change exceeds the detector's 20 % significance threshold, so generated tones loop back through the FFT/detector chain with the same classification.

## Interface
- PHASE_W, 32: phase accumulator and increment width.
- SAMPLE_W, 8: output sample width; must be ≤ PHASE_W.
- STEP_SHIFT, 2: per-segment relative step is inc >> STEP_SHIFT (25 %).
- SAMPLE_DIV, 1: sample strobe period in PLAY cycles; must be ≥ 1.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- valid_in  input  1  request valid.
- ready_out  output  1  block idle and able to accept.
- tone_ident_in  input  3  000 neutral, 001 rising, 010 undulating, 100 falling.
- base_inc_in  input  PHASE_W  phase increment of segment 0.
- segment_length_in  input  32  PLAY cycles per segment; 0 is treated as 1.
- sample_out  output  SAMPLE_W  registered audio sample.
- sample_valid_out  output  1  sample strobe.
- segment_out  output  2  current segment index, 0–3.
- done_out  output  1  one-cycle pulse at contour end.
- error_out  output  1  one-cycle pulse when an invalid tone code is rejected.

## Operation
- States: IDLE, LOAD, PLAY, DONE.
- **IDLE**
  - ready_out = 1.
  - On valid_in && ready_out, latch tone, base and length.
  - Valid code: go to LOAD and drop ready_out.
  - Invalid code (anything other than the four above): pulse error_out, stay in IDLE, keep ready_out = 1.
- **LOAD**
  - inc = base, phase = 0, seg = 0, seg_cnt = 0, div_cnt = 0.
  - Go to PLAY.
- **PLAY**, every cycle:
  - phase <= phase + inc, wrapping modulo 2^PHASE_W.
  - seg_cnt increments.
  - sample_valid_out = 1 when div_cnt == 0; div_cnt counts modulo SAMPLE_DIV.
  - sample_out is computed from the pre-add phase.
  - When seg_cnt == L−1:
    - If seg < 3: seg++, seg_cnt = 0, inc = next(inc). The new inc applies from the next cycle.
    - If seg == 3: go to DONE.
- **DONE**: done_out = 1 for one cycle, then IDLE.
- Step directions per boundary (seg 0→1, 1→2, 2→3), using the detector's encoding 00 = none, 01 = up, 11 = down:
  - neutral: 00, 00, 00.
  - rising: 01, 01, 01.
  - undulating: 01, 01, 11.
  - falling: 11, 11, 11.
- next(inc) arithmetic:
  - up: inc + (inc >> STEP_SHIFT), computed PHASE_W+1 wide, saturating to all-ones on carry.
  - down: inc − (inc >> STEP_SHIFT). This never underflows.
- sample_out: sawtooth, phase[PHASE_W−1 -: SAMPLE_W]. Square wave when the macro below is defined.
- valid_in outside IDLE is ignored. No queueing.
- base_inc_in = 0 is legal: the output is a constant sample of 0.

## Timing
- Accept is sampled at edge N.
- LOAD occupies cycle N+1; ready_out is low from N+1.
- PLAY occupies cycles N+2 through N+1+4L, where L = max(segment_length_in, 1).
- done_out is high in cycle N+2+4L.
- ready_out is high again from N+3+4L.
- The first sample_valid_out is in cycle N+2 with sample_out = 0.
- segment_out changes on the same edge as inc.
- Reset values:
  - ready_out = 1.
  - sample_out, sample_valid_out, segment_out, done_out, error_out = 0.
  - State = IDLE; phase and inc = 0.
- Reset mid-PLAY aborts the contour. There is no done_out and no error_out; the block is ready the cycle after reset deasserts.
- Reset has priority over a simultaneous valid_in.

## Configuration
- TONE_GEN_SQUARE_EN defined: sample_out = {SAMPLE_W{phase[PHASE_W−1]}}, a square wave.
- TONE_GEN_SQUARE_EN undefined: sawtooth from the top SAMPLE_W phase bits.
- Timing and all handshake behaviour are identical in both builds.

## Structure
- Package tone_pkg holds:
  - tone code localparams TONE_NEUTRAL, TONE_RISING, TONE_UNDULATING, TONE_FALLING;
  - the 2-bit step encoding (STEP_NONE/UP/DOWN);
  - the state enum typedef;
  - a function mapping tone code to the three step codes.
- The detector is to be migrated to this same package.
- Sub-module tone_nco contains the phase register, the add, the sample formatting (including the macro) and the SAMPLE_DIV strobe counter.
- The top level keeps the FSM, the segment counter and the increment-update arithmetic.

## Test plan
- Neutral, base 0x0100_0000, L = 8:
  - 32 PLAY cycles, inc constant.
  - Phase = 0x2000_0000 after PLAY.
  - done_out exactly at N+34.
- Rising, same base: inc sequence 0x0100_0000, 0x0140_0000, 0x0190_0000, 0x01F4_0000; segment_out 0→3.
- Falling: 0x0100_0000, 0x00C0_0000, 0x0090_0000, 0x006C_0000.
- Undulating: 0x0100_0000, 0x0140_0000, 0x0190_0000, 0x012C_0000.
- Edge cases:
  - tone 3'b011 → one error_out pulse, ready_out stays 1, no sample_valid_out.
  - Rising with base 0xF000_0000 → segment 1 inc saturates to 0xFFFF_FFFF.
- rst_in asserted mid-segment 2:
  - All outputs return to reset values, no done_out.
  - The next request plays normally.
  - valid_in held during PLAY is ignored.
